// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the Mini SRC datapath.
// Fetch T0-T2, decode in T3, execute T3-T6 for ALU, MUL/DIV, NOP, HALT.
module control_sequencer #(
    parameter int RESET_ONEHOT_WIDTH = 16
) (
    input  logic                          clock,
    input  logic                          clear,
    input  logic [31:0]                   IR,
    input  logic                          mem_ready,
    output logic [RESET_ONEHOT_WIDTH-1:0] Rin,
    output logic [RESET_ONEHOT_WIDTH-1:0] Rout,
    output logic                          PCout,
    output logic                          PCin,
    output logic                          IncPC,
    output logic                          MARin,
    output logic                          MDRin,
    output logic                          MDRout,
    output logic                          IRin,
    output logic                          Yin,
    output logic                          Zin,
    output logic                          Zlowout,
    output logic                          Zhighout,
    output logic                          HIin,
    output logic                          LOin,
    output logic                          Read,
    output logic                          ADD,
    output logic                          SUB,
    output logic                          AND,
    output logic                          OR,
    output logic                          SHR,
    output logic                          SHRA,
    output logic                          SHL,
    output logic                          ROR,
    output logic                          ROL,
    output logic                          NEG,
    output logic                          NOT,
    output logic                          MUL,
    output logic                          DIV,
    output logic                          run,
    output logic                          illegal
);

    typedef enum logic [3:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6, HALT
    } state_t;

    typedef enum logic [2:0] {
        C_REG3, C_UNARY, C_MULDIV, C_NOP, C_HALT, C_ILL
    } cls_t;

    state_t      state;
    state_t      next;
    logic [4:0]  op_q;
    logic [3:0]  ra_q;
    logic [3:0]  rb_q;
    logic [3:0]  rc_q;
    logic        t1_first;
    logic [4:0]  f_op;
    logic [3:0]  f_ra;
    logic [3:0]  f_rb;
    logic [3:0]  f_rc;
    cls_t        cls;
    logic [12:0] alu_vec;
    logic        alu_on;
    logic        unused_ir;

    assign unused_ir = ^IR[14:0];

    function automatic cls_t classify(input logic [4:0] op);
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
            5'b01000, 5'b01001, 5'b01010, 5'b01011: classify = C_REG3;
            5'b10001, 5'b10010:                     classify = C_UNARY;
            5'b01111, 5'b10000:                     classify = C_MULDIV;
            5'b11010:                               classify = C_NOP;
            5'b11011:                               classify = C_HALT;
            default:                                classify = C_ILL;
        endcase
    endfunction

    // Bit order: ADD SUB AND OR SHR SHRA SHL ROR ROL NEG NOT MUL DIV
    function automatic logic [12:0] alu_decode(input logic [4:0] op);
        case (op)
            5'b00011: alu_decode = 13'h1000;
            5'b00100: alu_decode = 13'h0800;
            5'b00101: alu_decode = 13'h0400;
            5'b00110: alu_decode = 13'h0200;
            5'b01001: alu_decode = 13'h0100;
            5'b01010: alu_decode = 13'h0080;
            5'b01011: alu_decode = 13'h0040;
            5'b00111: alu_decode = 13'h0020;
            5'b01000: alu_decode = 13'h0010;
            5'b10001: alu_decode = 13'h0008;
            5'b10010: alu_decode = 13'h0004;
            5'b10000: alu_decode = 13'h0002;
            5'b01111: alu_decode = 13'h0001;
            default:  alu_decode = 13'h0000;
        endcase
    endfunction

    function automatic logic [RESET_ONEHOT_WIDTH-1:0] onehot(
        input logic [3:0] idx
    );
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    // T3 decodes the live IR; later steps use the copy latched in T3
    assign f_op    = (state == T3) ? IR[31:27] : op_q;
    assign f_ra    = (state == T3) ? IR[26:23] : ra_q;
    assign f_rb    = (state == T3) ? IR[22:19] : rb_q;
    assign f_rc    = (state == T3) ? IR[18:15] : rc_q;
    assign cls     = classify(f_op);
    assign alu_vec = alu_decode(f_op);

    assign {ADD, SUB, AND, OR, SHR, SHRA, SHL,
            ROR, ROL, NEG, NOT, MUL, DIV} = alu_on ? alu_vec : 13'h0;

    // State register; clear aborts any instruction back to IDLE
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) state <= IDLE;
        else        state <= next;
    end

    // Latch instruction fields during T3 for use in T4-T6
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            op_q <= '0;
            ra_q <= '0;
            rb_q <= '0;
            rc_q <= '0;
        end else if (state == T3) begin
            op_q <= IR[31:27];
            ra_q <= IR[26:23];
            rb_q <= IR[22:19];
            rc_q <= IR[18:15];
        end
    end

    // Marks the first T1 cycle so PC loads once across memory waits
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) t1_first <= 1'b0;
        else        t1_first <= (state == T0);
    end

    // Next-state and strobe decode per state
    always_comb begin
        next     = state;
        Rin      = '0;
        Rout     = '0;
        PCout    = 1'b0;
        PCin     = 1'b0;
        IncPC    = 1'b0;
        MARin    = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        Read     = 1'b0;
        alu_on   = 1'b0;
        illegal  = 1'b0;
        run      = (state != IDLE) && (state != HALT);
        case (state)
            IDLE: next = T0;
            T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
                next  = T1;
            end
            T1: begin
                Zlowout = 1'b1;
                Read    = 1'b1;
                PCin    = t1_first;
                if (mem_ready) begin
                    MDRin = 1'b1;
                    next  = T2;
                end
            end
            T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
                next   = T3;
            end
            T3: begin
                case (cls)
                    C_REG3: begin
                        Rout = onehot(f_rb);
                        Yin  = 1'b1;
                        next = T4;
                    end
                    C_UNARY: begin
                        Rout   = onehot(f_rb);
                        alu_on = 1'b1;
                        Zin    = 1'b1;
                        next   = T4;
                    end
                    C_MULDIV: begin
                        Rout = onehot(f_ra);
                        Yin  = 1'b1;
                        next = T4;
                    end
                    C_HALT:  next = HALT;
                    C_NOP:   next = T0;
                    default: begin
                        illegal = 1'b1;
                        next    = T0;
                    end
                endcase
            end
            T4: begin
                case (cls)
                    C_REG3: begin
                        Rout   = onehot(f_rc);
                        alu_on = 1'b1;
                        Zin    = 1'b1;
                        next   = T5;
                    end
                    C_UNARY: begin
                        Zlowout = 1'b1;
                        Rin     = onehot(f_ra);
                        next    = T0;
                    end
                    C_MULDIV: begin
                        Rout   = onehot(f_rb);
                        alu_on = 1'b1;
                        Zin    = 1'b1;
                        next   = T5;
                    end
                    default: next = T0;
                endcase
            end
            T5: begin
                case (cls)
                    C_REG3: begin
                        Zlowout = 1'b1;
                        Rin     = onehot(f_ra);
                        next    = T0;
                    end
                    C_MULDIV: begin
                        Zlowout = 1'b1;
                        LOin    = 1'b1;
                        next    = T6;
                    end
                    default: next = T0;
                endcase
            end
            T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                next     = T0;
            end
            HALT:    next = HALT;
            default: next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer.
// Per-cycle vector table fed through an expected-output scoreboard.
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic [31:0] IR = '0;
    logic        mem_ready = 1'b0;
    logic [15:0] Rin, Rout;
    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin;
    logic Zlowout, Zhighout, HIin, LOin, Read;
    logic ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT, MUL, DIV;
    logic run, illegal;

    always #5 clock = ~clock;

    control_sequencer #(.RESET_ONEHOT_WIDTH(16)) dut (
        .clock(clock), .clear(clear), .IR(IR), .mem_ready(mem_ready),
        .Rin(Rin), .Rout(Rout),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
        .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout),
        .HIin(HIin), .LOin(LOin), .Read(Read),
        .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .SHR(SHR),
        .SHRA(SHRA), .SHL(SHL), .ROR(ROR), .ROL(ROL), .NEG(NEG),
        .NOT(NOT), .MUL(MUL), .DIV(DIV),
        .run(run), .illegal(illegal)
    );

    typedef struct packed {
        logic [15:0] rin;
        logic [15:0] rout;
        logic [13:0] stb;
        logic [12:0] alu;
        logic        run;
        logic        ill;
    } out_t;

    typedef struct {
        logic [31:0] ir;
        logic        mr;
        out_t        exp;
        string       name;
    } vec_t;

    // strobe bits: PCout PCin IncPC MARin MDRin MDRout IRin Yin Zin
    //              Zlowout Zhighout HIin LOin Read
    localparam logic [13:0] S_PCOUT = 14'h2000, S_PCIN = 14'h1000;
    localparam logic [13:0] S_INCPC = 14'h0800, S_MARIN = 14'h0400;
    localparam logic [13:0] S_MDRIN = 14'h0200, S_MDROUT = 14'h0100;
    localparam logic [13:0] S_IRIN = 14'h0080, S_YIN = 14'h0040;
    localparam logic [13:0] S_ZIN = 14'h0020, S_ZLO = 14'h0010;
    localparam logic [13:0] S_ZHI = 14'h0008, S_HIIN = 14'h0004;
    localparam logic [13:0] S_LOIN = 14'h0002, S_READ = 14'h0001;
    localparam logic [12:0] A_ADD = 13'h1000, A_SUB = 13'h0800;
    localparam logic [12:0] A_OR = 13'h0200, A_ROR = 13'h0020;
    localparam logic [12:0] A_NEG = 13'h0008, A_NOT = 13'h0004;
    localparam logic [12:0] A_MUL = 13'h0002, A_DIV = 13'h0001;

    vec_t vecs[$];
    out_t sb[$];
    int   passed = 0;
    int   total = 0;
    out_t zero_o;

    function automatic out_t mk(logic [15:0] rin, logic [15:0] rout,
                                logic [13:0] stb, logic [12:0] alu = 13'h0,
                                logic r = 1'b1, logic ill = 1'b0);
        out_t o;
        o.rin = rin; o.rout = rout; o.stb = stb;
        o.alu = alu; o.run = r; o.ill = ill;
        return o;
    endfunction

    function automatic logic [31:0] enc(logic [4:0] op, logic [3:0] ra,
                                        logic [3:0] rb, logic [3:0] rc);
        return {op, ra, rb, rc, 15'h0};
    endfunction

    function automatic out_t sample();
        out_t o;
        o.rin  = Rin;
        o.rout = Rout;
        o.stb  = {PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin,
                  Zin, Zlowout, Zhighout, HIin, LOin, Read};
        o.alu  = {ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG,
                  NOT, MUL, DIV};
        o.run  = run;
        o.ill  = illegal;
        return o;
    endfunction

    task automatic compare(string name);
        out_t e, a;
        total++;
        if (sb.size() == 0) begin
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = sb.pop_front();
        a = sample();
        if (a === e) passed++;
        else $display("FAIL %s: got rin=%h rout=%h stb=%h alu=%h run=%b ill=%b want rin=%h rout=%h stb=%h alu=%h run=%b ill=%b",
                      name, a.rin, a.rout, a.stb, a.alu, a.run, a.ill,
                      e.rin, e.rout, e.stb, e.alu, e.run, e.ill);
    endtask

    task automatic expect_now(string name, out_t e);
        sb.push_back(e);
        #1;
        compare(name);
    endtask

    task automatic apply(vec_t v);
        @(negedge clock);
        IR = v.ir;
        mem_ready = v.mr;
        sb.push_back(v.exp);
        #1;
        compare(v.name);
    endtask

    task automatic row(string name, logic [31:0] ir, logic mr, out_t e);
        vec_t v;
        v.ir = ir; v.mr = mr; v.exp = e; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic fetch(string nm, logic [31:0] ir, int waits);
        row({nm, "_t0"}, ir, 1'b0,
            mk(16'h0, 16'h0, S_PCOUT | S_MARIN | S_INCPC | S_ZIN));
        for (int i = 0; i <= waits; i++)
            row({nm, "_t1"}, ir, (i == waits),
                mk(16'h0, 16'h0, S_ZLO | S_READ |
                   ((i == 0) ? S_PCIN : 14'h0) |
                   ((i == waits) ? S_MDRIN : 14'h0)));
        row({nm, "_t2"}, ir, 1'b1, mk(16'h0, 16'h0, S_MDROUT | S_IRIN));
    endtask

    task automatic add_instr(string nm, int waits);
        logic [31:0] ir;
        ir = 32'h18B98000;
        fetch(nm, ir, waits);
        row({nm, "_t3"}, ir, 1'b1, mk(16'h0, 16'h0080, S_YIN));
        row({nm, "_t4"}, ir, 1'b1, mk(16'h0, 16'h0008, S_ZIN, A_ADD));
        row({nm, "_t5"}, ir, 1'b1, mk(16'h0002, 16'h0, S_ZLO));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n1, n2;
        logic [31:0] ir;
        zero_o = mk(16'h0, 16'h0, 14'h0, 13'h0, 1'b0, 1'b0);

        add_instr("add", 2);
        ir = 32'h92380000;
        fetch("not", ir, 0);
        row("not_t3", ir, 1, mk(16'h0, 16'h0080, S_ZIN, A_NOT));
        row("not_t4", ir, 1, mk(16'h0010, 16'h0, S_ZLO));
        ir = 32'h81880000;
        fetch("mul", ir, 0);
        row("mul_t3", ir, 1, mk(16'h0, 16'h0008, S_YIN));
        row("mul_t4", ir, 1, mk(16'h0, 16'h0002, S_ZIN, A_MUL));
        row("mul_t5", ir, 1, mk(16'h0, 16'h0, S_ZLO | S_LOIN));
        row("mul_t6", ir, 1, mk(16'h0, 16'h0, S_ZHI | S_HIIN));
        ir = enc(5'b00100, 4'd5, 4'd5, 4'd5);
        fetch("sub", ir, 1);
        row("sub_t3", ir, 1, mk(16'h0, 16'h0020, S_YIN));
        row("sub_t4", 32'hFFFFFFFF, 1, mk(16'h0, 16'h0020, S_ZIN, A_SUB));
        row("sub_t5", 32'hFFFFFFFF, 1, mk(16'h0020, 16'h0, S_ZLO));
        ir = enc(5'b01111, 4'd0, 4'd9, 4'd0);
        fetch("div", ir, 0);
        row("div_t3", ir, 1, mk(16'h0, 16'h0001, S_YIN));
        row("div_t4", ir, 1, mk(16'h0, 16'h0200, S_ZIN, A_DIV));
        row("div_t5", ir, 1, mk(16'h0, 16'h0, S_ZLO | S_LOIN));
        row("div_t6", ir, 1, mk(16'h0, 16'h0, S_ZHI | S_HIIN));
        ir = enc(5'b10001, 4'd0, 4'd15, 4'd0);
        fetch("neg", ir, 0);
        row("neg_t3", ir, 1, mk(16'h0, 16'h8000, S_ZIN, A_NEG));
        row("neg_t4", ir, 1, mk(16'h0001, 16'h0, S_ZLO));
        ir = enc(5'b00111, 4'd2, 4'd10, 4'd12);
        fetch("ror", ir, 0);
        row("ror_t3", ir, 1, mk(16'h0, 16'h0400, S_YIN));
        row("ror_t4", ir, 1, mk(16'h0, 16'h1000, S_ZIN, A_ROR));
        row("ror_t5", ir, 1, mk(16'h0004, 16'h0, S_ZLO));
        ir = enc(5'b00110, 4'd14, 4'd0, 4'd6);
        fetch("or", ir, 0);
        row("or_t3", ir, 1, mk(16'h0, 16'h0001, S_YIN));
        row("or_t4", ir, 1, mk(16'h0, 16'h0040, S_ZIN, A_OR));
        row("or_t5", ir, 1, mk(16'h4000, 16'h0, S_ZLO));
        ir = 32'hD0000000;
        fetch("nop", ir, 0);
        row("nop_t3", ir, 1, mk(16'h0, 16'h0, 14'h0));
        ir = 32'hF8000000;
        fetch("ill", ir, 0);
        row("ill_t3", ir, 1, mk(16'h0, 16'h0, 14'h0, 13'h0, 1'b1, 1'b1));
        ir = 32'hD8000000;
        fetch("halt", ir, 0);
        row("halt_t3", ir, 1, mk(16'h0, 16'h0, 14'h0));
        for (int i = 0; i < 12; i++)
            row("halt_hold", 32'h18B98000, 1, zero_o);
        n1 = vecs.size();
        fetch("abort", 32'h18B98000, 0);
        row("abort_t3", 32'h18B98000, 1, mk(16'h0, 16'h0080, S_YIN));
        row("abort_t4", 32'h18B98000, 1,
            mk(16'h0, 16'h0008, S_ZIN, A_ADD));
        n2 = vecs.size();
        add_instr("restart", 1);
        row("restart_next_t0", 32'h0, 0,
            mk(16'h0, 16'h0, S_PCOUT | S_MARIN | S_INCPC | S_ZIN));

        #2 clear = 1'b0;
        expect_now("reset_async", zero_o);
        @(negedge clock);
        expect_now("reset_hold1", zero_o);
        @(negedge clock);
        expect_now("reset_hold2", zero_o);
        @(negedge clock);
        clear = 1'b1;
        expect_now("idle_release", zero_o);

        for (int i = 0; i < n1; i++) apply(vecs[i]);

        @(negedge clock);
        clear = 1'b0;
        expect_now("halt_clear", zero_o);
        @(negedge clock);
        clear = 1'b1;
        expect_now("halt_release", zero_o);

        for (int i = n1; i < n2; i++) apply(vecs[i]);
        #2 clear = 1'b0;
        expect_now("abort_async", zero_o);
        @(negedge clock);
        clear = 1'b1;
        expect_now("abort_release", zero_o);

        for (int i = n2; i < vecs.size(); i++) apply(vecs[i]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
